// File: rtl/lstm_layer1_ctrl_if.sv
// Layer-1 datapath control bundle: run handshake plus all layer-1 MAC/memory controls.
//   master: controller side (drives everything except start)
//   slave : datapath/requester side
interface lstm_layer1_ctrl_if #(
  parameter int unsigned ADDR_W = 12
);
  logic              start;
  logic              busy;
  logic              done;
  logic              acc_x_1;
  logic              acc_h_1;
  logic [ADDR_W-1:0] addr_x1;
  logic [ADDR_W-1:0] rd_addr_w_1;
  logic [ADDR_W-1:0] rd_addr_u_1;
  logic [ADDR_W-1:0] rd_addr_b_1;
  logic [ADDR_W-1:0] rd_addr_h1;
  logic [ADDR_W-1:0] rd_addr_c1;
  logic              wr_h1;
  logic [ADDR_W-1:0] wr_addr_h1;
  logic              wr_c1;
  logic [ADDR_W-1:0] wr_addr_c1;

  modport master (
    input  start,
    output busy, done, acc_x_1, acc_h_1,
    output addr_x1, rd_addr_w_1, rd_addr_u_1, rd_addr_b_1, rd_addr_h1, rd_addr_c1,
    output wr_h1, wr_addr_h1, wr_c1, wr_addr_c1
  );

  modport slave (
    output start,
    input  busy, done, acc_x_1, acc_h_1,
    input  addr_x1, rd_addr_w_1, rd_addr_u_1, rd_addr_b_1, rd_addr_h1, rd_addr_c1,
    input  wr_h1, wr_addr_h1, wr_c1, wr_addr_c1
  );
endinterface

// File: rtl/lstm_layer1_ctrl.sv
// Layer-1 LSTM control sequencer. For every timestep t and cell n it runs
// ACC (K cycles) -> DRAIN -> WRITE -> NEXT, producing all layer-1 datapath controls.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset
//   bus  - lstm_layer1_ctrl_if.master: start in; busy/done, acc enables,
//          read/write addresses and write strobes out (all registered)
module lstm_layer1_ctrl #(
  parameter int unsigned TIMESTEP    = 7,
  parameter int unsigned LAYR1_INPUT = 53,
  parameter int unsigned LAYR1_CELL  = 53,
  parameter int unsigned ADDR_W      = 12
) (
  input  logic                clk,
  input  logic                rst,
  lstm_layer1_ctrl_if.master  bus
);

  localparam int unsigned K   = (LAYR1_INPUT > LAYR1_CELL) ? LAYR1_INPUT : LAYR1_CELL;
  localparam int unsigned K_W = $clog2(K + 1);
  localparam int unsigned N_W = $clog2(LAYR1_CELL + 1);
  localparam int unsigned T_W = $clog2(TIMESTEP + 1);

  // Largest address any output can take; must fit in ADDR_W.
  localparam longint unsigned MAX_WR = longint'(TIMESTEP + 1) * longint'(LAYR1_CELL) - 1;
  localparam longint unsigned MAX_X  = longint'(TIMESTEP) * longint'(LAYR1_INPUT) - 1;
  localparam longint unsigned MAX_W  = longint'(LAYR1_CELL) * longint'(LAYR1_INPUT) - 1;
  localparam longint unsigned MAX_U  = longint'(LAYR1_CELL) * longint'(LAYR1_CELL) - 1;
  localparam bit CFG_OK = (MAX_WR < (64'd1 << ADDR_W)) && (MAX_X < (64'd1 << ADDR_W)) &&
                          (MAX_W  < (64'd1 << ADDR_W)) && (MAX_U < (64'd1 << ADDR_W));

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ACC   = 3'd1,
    S_DRAIN = 3'd2,
    S_WRITE = 3'd3,
    S_NEXT  = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [T_W-1:0]    t_q, t_d;
  logic [N_W-1:0]    n_q, n_d;
  logic [K_W-1:0]    k_q, k_d;
  // Running products replacing multipliers: t*INPUT, t*CELL, n*INPUT, n*CELL.
  logic [ADDR_W-1:0] xt_base_q, xt_base_d;
  logic [ADDR_W-1:0] ht_base_q, ht_base_d;
  logic [ADDR_W-1:0] wn_base_q, wn_base_d;
  logic [ADDR_W-1:0] un_base_q, un_base_d;

  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              acc_x_q, acc_x_d;
  logic              acc_h_q, acc_h_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_x_q, addr_x_d;
  logic [ADDR_W-1:0] addr_w_q, addr_w_d;
  logic [ADDR_W-1:0] addr_u_q, addr_u_d;
  logic [ADDR_W-1:0] addr_b_q, addr_b_d;
  logic [ADDR_W-1:0] addr_h_q, addr_h_d;
  logic [ADDR_W-1:0] addr_c_q, addr_c_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [K_W-1:0]    kx, kh;

  // Next state, counters and the registered outputs derived from them.
  always_comb begin
    state_d   = state_q;
    t_d       = t_q;
    n_d       = n_q;
    k_d       = k_q;
    xt_base_d = xt_base_q;
    ht_base_d = ht_base_q;
    wn_base_d = wn_base_q;
    un_base_d = un_base_q;
    done_d    = 1'b0;
    addr_x_d  = addr_x_q;
    addr_w_d  = addr_w_q;
    addr_u_d  = addr_u_q;
    addr_b_d  = addr_b_q;
    addr_h_d  = addr_h_q;
    addr_c_d  = addr_c_q;
    wr_addr_d = wr_addr_q;

    unique case (state_q)
      // The done cycle is IDLE entry; start is not accepted until the next cycle.
      S_IDLE: begin
        if (bus.start && !done_q) begin
          state_d   = S_ACC;
          t_d       = '0;
          n_d       = '0;
          k_d       = '0;
          xt_base_d = '0;
          ht_base_d = '0;
          wn_base_d = '0;
          un_base_d = '0;
        end
      end
      S_ACC: begin
        if (k_q == K_W'(K - 1)) state_d = S_DRAIN;
        else                    k_d     = k_q + K_W'(1);
      end
      S_DRAIN: state_d = S_WRITE;
      S_WRITE: state_d = S_NEXT;
      S_NEXT: begin
        k_d     = '0;
        state_d = S_ACC;
        if (n_q != N_W'(LAYR1_CELL - 1)) begin
          n_d       = n_q + N_W'(1);
          wn_base_d = wn_base_q + ADDR_W'(LAYR1_INPUT);
          un_base_d = un_base_q + ADDR_W'(LAYR1_CELL);
        end else begin
          n_d       = '0;
          wn_base_d = '0;
          un_base_d = '0;
          if (t_q != T_W'(TIMESTEP - 1)) begin
            t_d       = t_q + T_W'(1);
            xt_base_d = xt_base_q + ADDR_W'(LAYR1_INPUT);
            ht_base_d = ht_base_q + ADDR_W'(LAYR1_CELL);
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // k clamped to each vector's last index so addresses hold once k runs past it.
    kx = (k_d < K_W'(LAYR1_INPUT)) ? k_d : K_W'(LAYR1_INPUT - 1);
    kh = (k_d < K_W'(LAYR1_CELL))  ? k_d : K_W'(LAYR1_CELL - 1);

    busy_d  = (state_d != S_IDLE);
    acc_x_d = (state_d == S_ACC) && (k_d < K_W'(LAYR1_INPUT));
    acc_h_d = (state_d == S_ACC) && (k_d < K_W'(LAYR1_CELL));
    wr_d    = (state_d == S_WRITE);

    if (state_d == S_ACC) begin
      addr_x_d = xt_base_d + ADDR_W'(kx);
      addr_w_d = wn_base_d + ADDR_W'(kx);
      addr_u_d = un_base_d + ADDR_W'(kh);
      addr_h_d = ht_base_d + ADDR_W'(kh);
    end
    if (state_d != S_IDLE) begin
      addr_b_d = ADDR_W'(n_d);
      addr_c_d = ht_base_d + ADDR_W'(n_d);
    end
    // h/c region 0..CELL-1 is the initial state, so writes land one timestep up.
    if (wr_d) wr_addr_d = ht_base_d + ADDR_W'(LAYR1_CELL) + ADDR_W'(n_d);
  end

  // State, counters and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      t_q       <= '0;
      n_q       <= '0;
      k_q       <= '0;
      xt_base_q <= '0;
      ht_base_q <= '0;
      wn_base_q <= '0;
      un_base_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      acc_x_q   <= 1'b0;
      acc_h_q   <= 1'b0;
      wr_q      <= 1'b0;
      addr_x_q  <= '0;
      addr_w_q  <= '0;
      addr_u_q  <= '0;
      addr_b_q  <= '0;
      addr_h_q  <= '0;
      addr_c_q  <= '0;
      wr_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      t_q       <= t_d;
      n_q       <= n_d;
      k_q       <= k_d;
      xt_base_q <= xt_base_d;
      ht_base_q <= ht_base_d;
      wn_base_q <= wn_base_d;
      un_base_q <= un_base_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      acc_x_q   <= acc_x_d;
      acc_h_q   <= acc_h_d;
      wr_q      <= wr_d;
      addr_x_q  <= addr_x_d;
      addr_w_q  <= addr_w_d;
      addr_u_q  <= addr_u_d;
      addr_b_q  <= addr_b_d;
      addr_h_q  <= addr_h_d;
      addr_c_q  <= addr_c_d;
      wr_addr_q <= wr_addr_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.acc_x_1     = acc_x_q;
  assign bus.acc_h_1     = acc_h_q;
  assign bus.addr_x1     = addr_x_q;
  assign bus.rd_addr_w_1 = addr_w_q;
  assign bus.rd_addr_u_1 = addr_u_q;
  assign bus.rd_addr_b_1 = addr_b_q;
  assign bus.rd_addr_h1  = addr_h_q;
  assign bus.rd_addr_c1  = addr_c_q;
  assign bus.wr_h1       = wr_q;
  assign bus.wr_c1       = wr_q;
  assign bus.wr_addr_h1  = wr_addr_q;
  assign bus.wr_addr_c1  = wr_addr_q;

  // Configurations whose addresses overflow ADDR_W are not supported.
  a_cfg_fits: assert property (@(posedge clk) disable iff (!rst) CFG_OK)
    else $error("lstm_layer1_ctrl: address range exceeds ADDR_W");

endmodule

// File: tb/tb_lstm_layer1_ctrl.sv
module tb_lstm_layer1_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  lstm_layer1_ctrl_if #(.ADDR_W(12)) d_if ();
  lstm_layer1_ctrl_if #(.ADDR_W(12)) s_if ();
  lstm_layer1_ctrl_if #(.ADDR_W(12)) a_if ();

  lstm_layer1_ctrl #(.TIMESTEP(7), .LAYR1_INPUT(53), .LAYR1_CELL(53), .ADDR_W(12))
    u_dut_def (.clk(clk), .rst(rst_n), .bus(d_if));
  lstm_layer1_ctrl #(.TIMESTEP(2), .LAYR1_INPUT(3), .LAYR1_CELL(2), .ADDR_W(12))
    u_dut_small (.clk(clk), .rst(rst_n), .bus(s_if));
  lstm_layer1_ctrl #(.TIMESTEP(1), .LAYR1_INPUT(4), .LAYR1_CELL(2), .ADDR_W(12))
    u_dut_asym (.clk(clk), .rst(rst_n), .bus(a_if));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Starts a default-config run and follows it to done; optionally pulses start at cycle glitch_j.
  task automatic run_default(input int glitch_j, output int done_j, output int nwr,
                             output logic [11:0] last_wr);
    @(negedge clk); d_if.start = 1'b1;
    @(negedge clk); d_if.start = 1'b0;
    done_j = -1; nwr = 0; last_wr = '0;
    for (int j = 0; j < 25000; j++) begin
      if (d_if.wr_h1) begin nwr++; last_wr = d_if.wr_addr_h1; end
      if (d_if.done) begin done_j = j; break; end
      d_if.start = (j == glitch_j);
      @(negedge clk);
    end
    d_if.start = 1'b0;
  endtask

  task automatic test_reset();
    int bad;
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({d_if.busy, d_if.done, d_if.acc_x_1, d_if.acc_h_1, d_if.wr_h1, d_if.wr_c1} !== 6'b0) begin
      errors++; $display("FAIL reset_flags: got %b expected 000000",
        {d_if.busy, d_if.done, d_if.acc_x_1, d_if.acc_h_1, d_if.wr_h1, d_if.wr_c1});
    end
    checks++;
    if (s_if.addr_x1 !== 12'd0 || s_if.wr_addr_h1 !== 12'd0 || a_if.busy !== 1'b0) begin
      errors++; $display("FAIL reset_other: got x=%0d wr=%0d busy=%b expected 0",
        s_if.addr_x1, s_if.wr_addr_h1, a_if.busy);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); d_if.start = 1'b1;
    @(negedge clk); d_if.start = 1'b0;
    repeat (30) @(negedge clk);
    checks++;
    if (d_if.busy !== 1'b1 || d_if.addr_x1 !== 12'd30 || d_if.rd_addr_u_1 !== 12'd30) begin
      errors++; $display("FAIL reset_prerun: got busy=%b x=%0d u=%0d expected 1/30/30",
        d_if.busy, d_if.addr_x1, d_if.rd_addr_u_1);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({d_if.busy, d_if.acc_x_1, d_if.acc_h_1} !== 3'b0) begin
      errors++; $display("FAIL reset_mid_flags: got %b expected 000",
        {d_if.busy, d_if.acc_x_1, d_if.acc_h_1});
    end
    checks++;
    if (d_if.addr_x1 !== 12'd0 || d_if.rd_addr_w_1 !== 12'd0 || d_if.rd_addr_u_1 !== 12'd0 ||
        d_if.rd_addr_h1 !== 12'd0) begin
      errors++; $display("FAIL reset_mid_addr: got x=%0d w=%0d u=%0d h=%0d expected 0",
        d_if.addr_x1, d_if.rd_addr_w_1, d_if.rd_addr_u_1, d_if.rd_addr_h1);
    end
    @(negedge clk); rst_n = 1'b1;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (d_if.busy !== 1'b0 || d_if.acc_x_1 !== 1'b0 || d_if.wr_h1 !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL reset_idle_after: got %0d active cycles expected 0", bad);
    end
  endtask

  task automatic test_small();
    int done_j;
    int nwr;
    logic [11:0] wr_seq [4];
    int exp_x [3] = '{3, 4, 5};
    int exp_h [3] = '{2, 3, 3};
    int exp_wr [4] = '{2, 3, 4, 5};
    done_j = -1; nwr = 0;
    @(negedge clk); s_if.start = 1'b1;
    @(negedge clk); s_if.start = 1'b0;
    checks++;
    if (s_if.busy !== 1'b1) begin
      errors++; $display("FAIL small_busy: got %b expected 1", s_if.busy);
    end
    for (int j = 0; j < 40; j++) begin
      if (s_if.wr_h1) begin
        if (nwr < 4) wr_seq[nwr] = s_if.wr_addr_h1;
        checks++;
        if (s_if.wr_c1 !== 1'b1 || s_if.wr_addr_c1 !== s_if.wr_addr_h1) begin
          errors++; $display("FAIL small_wr_c: got wr_c1=%b addr=%0d expected 1/%0d",
            s_if.wr_c1, s_if.wr_addr_c1, s_if.wr_addr_h1);
        end
        nwr++;
      end
      if (j >= 18 && j <= 20) begin
        checks++;
        if (s_if.addr_x1 !== 12'(exp_x[j-18]) || s_if.rd_addr_w_1 !== 12'(exp_x[j-18]) ||
            s_if.rd_addr_h1 !== 12'(exp_h[j-18])) begin
          errors++; $display("FAIL small_acc_addr j=%0d: got x=%0d w=%0d h=%0d expected %0d/%0d/%0d",
            j, s_if.addr_x1, s_if.rd_addr_w_1, s_if.rd_addr_h1, exp_x[j-18], exp_x[j-18], exp_h[j-18]);
        end
      end
      if (j == 18) begin
        checks++;
        if (s_if.rd_addr_b_1 !== 12'd1 || s_if.rd_addr_c1 !== 12'd3) begin
          errors++; $display("FAIL small_bc: got b=%0d c=%0d expected 1/3",
            s_if.rd_addr_b_1, s_if.rd_addr_c1);
        end
      end
      if (s_if.done) begin done_j = j; break; end
      @(negedge clk);
    end
    checks++;
    if (done_j != 24) begin
      errors++; $display("FAIL small_run_len: got %0d expected 24", done_j);
    end
    checks++;
    if (s_if.busy !== 1'b0) begin
      errors++; $display("FAIL small_busy_at_done: got %b expected 0", s_if.busy);
    end
    checks++;
    if (nwr != 4) begin
      errors++; $display("FAIL small_wr_count: got %0d expected 4", nwr);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i < nwr && wr_seq[i] !== 12'(exp_wr[i])) begin
        errors++; $display("FAIL small_wr_seq[%0d]: got %0d expected %0d", i, wr_seq[i], exp_wr[i]);
      end
    end
    // start during the done cycle must be ignored
    s_if.start = 1'b1;
    @(negedge clk); s_if.start = 1'b0;
    @(negedge clk);
    checks++;
    if (s_if.busy !== 1'b0) begin
      errors++; $display("FAIL small_start_in_done: got busy=%b expected 0", s_if.busy);
    end
    s_if.start = 1'b1;
    @(negedge clk); s_if.start = 1'b0;
    checks++;
    if (s_if.busy !== 1'b1 || s_if.addr_x1 !== 12'd0) begin
      errors++; $display("FAIL small_restart: got busy=%b x=%0d expected 1/0", s_if.busy, s_if.addr_x1);
    end
  endtask

  task automatic test_asym();
    logic ex_x [14] = '{1,1,1,1,0,0,0, 1,1,1,1,0,0,0};
    logic ex_h [14] = '{1,1,0,0,0,0,0, 1,1,0,0,0,0,0};
    int   ex_u [14] = '{0,1,1,1,1,1,1, 2,3,3,3,3,3,3};
    int   done_j;
    done_j = -1;
    @(negedge clk); a_if.start = 1'b1;
    @(negedge clk); a_if.start = 1'b0;
    for (int j = 0; j < 30; j++) begin
      if (j < 14) begin
        checks++;
        if (a_if.acc_x_1 !== ex_x[j] || a_if.acc_h_1 !== ex_h[j] || a_if.rd_addr_u_1 !== 12'(ex_u[j])) begin
          errors++; $display("FAIL asym j=%0d: got ax=%b ah=%b u=%0d expected %b/%b/%0d",
            j, a_if.acc_x_1, a_if.acc_h_1, a_if.rd_addr_u_1, ex_x[j], ex_h[j], ex_u[j]);
        end
        checks++;
        if (a_if.wr_h1 !== ((j == 5) || (j == 12))) begin
          errors++; $display("FAIL asym_wr j=%0d: got %b expected %b", j, a_if.wr_h1, (j == 5) || (j == 12));
        end
      end
      if (j == 10) begin
        checks++;
        if (a_if.rd_addr_w_1 !== 12'd7) begin
          errors++; $display("FAIL asym_w_last: got %0d expected 7", a_if.rd_addr_w_1);
        end
      end
      if (j == 12) begin
        checks++;
        if (a_if.wr_addr_h1 !== 12'd3) begin
          errors++; $display("FAIL asym_wr_addr: got %0d expected 3", a_if.wr_addr_h1);
        end
      end
      if (a_if.done) begin done_j = j; break; end
      @(negedge clk);
    end
    checks++;
    if (done_j != 14) begin
      errors++; $display("FAIL asym_run_len: got %0d expected 14", done_j);
    end
  endtask

  task automatic test_default();
    int done_j, nwr;
    logic [11:0] last_wr;
    run_default(-1, done_j, nwr, last_wr);
    checks++;
    if (done_j != 20776) begin
      errors++; $display("FAIL default_run_len: got %0d expected 20776", done_j);
    end
    checks++;
    if (nwr != 371) begin
      errors++; $display("FAIL default_wr_count: got %0d expected 371", nwr);
    end
    checks++;
    if (last_wr !== 12'd423) begin
      errors++; $display("FAIL default_last_wr: got %0d expected 423", last_wr);
    end
  endtask

  task automatic test_start_while_busy();
    int done_j, nwr;
    logic [11:0] last_wr;
    run_default(100, done_j, nwr, last_wr);
    checks++;
    if (done_j != 20776 || nwr != 371) begin
      errors++; $display("FAIL busy_start_ignored: got len=%0d wr=%0d expected 20776/371", done_j, nwr);
    end
  endtask

  task automatic test_reset_in_write();
    int done_j, nwr;
    logic [11:0] last_wr;
    @(negedge clk); d_if.start = 1'b1;
    @(negedge clk); d_if.start = 1'b0;
    checks++;
    if (d_if.busy !== 1'b1) begin
      errors++; $display("FAIL back_to_back_start: got busy=%b expected 1", d_if.busy);
    end
    repeat (614) @(negedge clk);
    checks++;
    if (d_if.wr_h1 !== 1'b1 || d_if.wr_addr_h1 !== 12'd63) begin
      errors++; $display("FAIL cell10_write: got wr=%b addr=%0d expected 1/63", d_if.wr_h1, d_if.wr_addr_h1);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (d_if.wr_h1 !== 1'b0 || d_if.wr_c1 !== 1'b0 || d_if.busy !== 1'b0) begin
      errors++; $display("FAIL write_reset: got wr_h1=%b wr_c1=%b busy=%b expected 0",
        d_if.wr_h1, d_if.wr_c1, d_if.busy);
    end
    @(negedge clk); rst_n = 1'b1;
    run_default(-1, done_j, nwr, last_wr);
    checks++;
    if (done_j != 20776 || nwr != 371 || last_wr !== 12'd423) begin
      errors++; $display("FAIL rerun_after_reset: got len=%0d wr=%0d last=%0d expected 20776/371/423",
        done_j, nwr, last_wr);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    d_if.start = 1'b0;
    s_if.start = 1'b0;
    a_if.start = 1'b0;
    test_reset();
    test_small();
    test_asym();
    test_default();
    test_start_while_busy();
    test_reset_in_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
